// File: rtl/test_status_port_pkg.sv
// =============================================================================
// Module      : test_status_port_pkg
// Description : Register offsets, FSM encodings and the status-word packer
//               shared by the test status port and its bench-side consumers.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package test_status_port_pkg;

   // Register offsets within the 16-byte block (byte offsets, bits [3:0])
   localparam logic [3:0] TSP_OFF_TOHOST  = 4'h0;
   localparam logic [3:0] TSP_OFF_CONSOLE = 4'h4;
   localparam logic [3:0] TSP_OFF_CYCLES  = 4'h8;
   localparam logic [3:0] TSP_OFF_STATUS  = 4'hC;

   // Test FSM encodings
   localparam logic [1:0] TSP_RUN     = 2'd0;
   localparam logic [1:0] TSP_PASS    = 2'd1;
   localparam logic [1:0] TSP_FAIL    = 2'd2;
   localparam logic [1:0] TSP_TIMEOUT = 2'd3;

   // TOHOST value that reports success; any other odd value is a failure
   localparam logic [31:0] TSP_PASS_VALUE = 32'd1;

   function automatic logic [31:0] tsp_status_word(
      input logic [15:0] code,
      input logic        timeout,
      input logic        fail,
      input logic        pass,
      input logic        done
   );
      return {code, 12'd0, timeout, fail, pass, done};
   endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// =============================================================================
// Module      : sync_fifo
// Description : Single-clock show-ahead FIFO. DEPTH must be a power of two.
//               A push while full is accepted only when a pop happens too.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic [WIDTH-1:0]       wrData,
   input  logic                   pop,
   output logic [WIDTH-1:0]       rdData,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned c_AW = $clog2(DEPTH);
   localparam int unsigned c_CW = c_AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [c_AW-1:0]  r_wr_ptr;
   logic [c_AW-1:0]  r_rd_ptr;
   logic [c_CW-1:0]  r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign empty     = (r_count == '0);
   assign full      = (r_count == c_CW'(DEPTH));
   assign w_do_pop  = pop & ~empty;
   assign w_do_push = push & (~full | w_do_pop);
   assign rdData    = r_mem[r_rd_ptr];
   assign count     = r_count;

   // Storage is left unreset; only pointers and occupancy define contents
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= wrData;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/test_status_port.sv
// =============================================================================
// Module      : test_status_port
// Description : Memory-mapped test completion port: TOHOST pass/fail, console
//               byte stream, cycle counter and watchdog. Macro TSP_CONSOLE_EN
//               enables the console FIFO; without it CONSOLE is inert.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module test_status_port
   import test_status_port_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR      = 32'hFFFF_FF00,
   parameter int unsigned TIMEOUT_CYCLES = 50000,
   parameter int unsigned FIFO_DEPTH     = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] busAddr,
   input  logic [31:0] busWrData,
   input  logic        busWe,
   input  logic        busRe,
   output logic [31:0] busRdData,
   output logic        done,
   output logic        pass,
   output logic        fail,
   output logic        timeout,
   output logic [15:0] failCode,
   output logic        conValid,
   output logic [7:0]  conData,
   input  logic        conReady
);

   localparam bit          c_WD_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [31:0] c_WD_LAST = c_WD_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;
   localparam int unsigned c_CNT_W   = $clog2(FIFO_DEPTH) + 1;

   logic [1:0]  r_state;
   logic [1:0]  w_state_next;
   logic [15:0] r_fail_code;
   logic [15:0] w_fail_code_next;
   logic        r_done, r_pass, r_fail, r_timeout;
   logic        w_done_next, w_pass_next, w_fail_next, w_timeout_next;
   logic [31:0] r_cycles;
   logic [31:0] r_wd;
   logic [31:0] r_rd_data;
   logic [31:0] w_rd_data;
   logic [31:0] w_con_occ;
   logic        w_hit;
   logic [3:0]  w_off;
   logic        w_wr_tohost;
   logic        w_wr_console;
   logic        w_wd_expire;

   assign w_hit        = (busAddr[31:4] == BASE_ADDR[31:4]);
   assign w_off        = {busAddr[3:2], 2'b00};
   assign w_wr_tohost  = busWe & w_hit & (w_off == TSP_OFF_TOHOST);
   assign w_wr_console = busWe & w_hit & (w_off == TSP_OFF_CONSOLE);
   assign w_wd_expire  = c_WD_EN && (r_wd == c_WD_LAST);

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state     <= TSP_RUN;
         r_fail_code <= 16'd0;
         r_done      <= 1'b0;
         r_pass      <= 1'b0;
         r_fail      <= 1'b0;
         r_timeout   <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_fail_code <= w_fail_code_next;
         r_done      <= w_done_next;
         r_pass      <= w_pass_next;
         r_fail      <= w_fail_next;
         r_timeout   <= w_timeout_next;
      end
   end

   // A firmware verdict in the expiry cycle takes priority over the watchdog
   always_comb begin
      w_state_next     = r_state;
      w_fail_code_next = r_fail_code;
      case (r_state)
         TSP_RUN: begin
            if (w_wr_tohost && (busWrData == TSP_PASS_VALUE)) begin
               w_state_next = TSP_PASS;
            end else if (w_wr_tohost && busWrData[0]) begin
               w_state_next     = TSP_FAIL;
               w_fail_code_next = busWrData[16:1];
            end else if (w_wd_expire) begin
               w_state_next = TSP_TIMEOUT;
            end
         end
         default: w_state_next = r_state;
      endcase
   end

   always_comb begin
      w_done_next    = (w_state_next != TSP_RUN);
      w_pass_next    = (w_state_next == TSP_PASS);
      w_fail_next    = (w_state_next == TSP_FAIL);
      w_timeout_next = (w_state_next == TSP_TIMEOUT);
   end

   assign done     = r_done;
   assign pass     = r_pass;
   assign fail     = r_fail;
   assign timeout  = r_timeout;
   assign failCode = r_fail_code;

   // ------------------------------------------------- cycle count / watchdog
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_cycles <= 32'd0;
         r_wd     <= 32'd0;
      end else if (r_state == TSP_RUN) begin
         r_cycles <= r_cycles + 32'd1;
         r_wd     <= r_wd + 32'd1;
      end
   end

   // ------------------------------------------------------------- console
`ifdef TSP_CONSOLE_EN
   logic [c_CNT_W-1:0] w_fifo_count;
   logic               w_fifo_full;
   logic               w_fifo_empty;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_con_fifo (
      .clk    (clk),
      .reset  (reset),
      .push   (w_wr_console),
      .wrData (busWrData[7:0]),
      .pop    (conReady),
      .rdData (conData),
      .full   (w_fifo_full),
      .empty  (w_fifo_empty),
      .count  (w_fifo_count)
   );

   assign conValid  = ~w_fifo_empty;
   assign w_con_occ = 32'(w_fifo_count);

   logic w_unused;
   assign w_unused = &{1'b0, busAddr[1:0], w_fifo_full};
`else
   assign conValid  = 1'b0;
   assign conData   = 8'd0;
   assign w_con_occ = 32'd0;

   logic w_unused;
   assign w_unused = &{1'b0, busAddr[1:0], conReady, w_wr_console, c_CNT_W[0]};
`endif

   // ---------------------------------------------------------------- reads
   always_comb begin
      w_rd_data = 32'd0;
      case (w_off)
         TSP_OFF_CONSOLE: w_rd_data = w_con_occ;
         TSP_OFF_CYCLES:  w_rd_data = r_cycles;
         TSP_OFF_STATUS:  w_rd_data = tsp_status_word(r_fail_code, r_timeout,
                                                      r_fail, r_pass, r_done);
         default:         w_rd_data = 32'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_rd_data <= 32'd0;
      end else if (busRe && w_hit) begin
         r_rd_data <= w_rd_data;
      end
   end

   assign busRdData = r_rd_data;

endmodule

`default_nettype wire

// File: tb/tb_test_status_port.sv
// Bench for test_status_port: directed scenarios plus random episodes,
// scored against a transaction-level model through an expectation queue.
`default_nettype none

module tb_test_status_port;

   localparam logic [31:0] BASE  = 32'hFFFF_FF00;
   localparam int          TO    = 100;
   localparam int          DEPTH = 8;
`ifdef TSP_CONSOLE_EN
   localparam bit CON_EN = 1'b1;
`else
   localparam bit CON_EN = 1'b0;
`endif

   logic        clk;
   logic        reset;
   logic [31:0] busAddr;
   logic [31:0] busWrData;
   logic        busWe;
   logic        busRe;
   logic [31:0] busRdData;
   logic        done, pass, fail, timeout;
   logic [15:0] failCode;
   logic        conValid;
   logic [7:0]  conData;
   logic        conReady;

   test_status_port #(
      .BASE_ADDR      (BASE),
      .TIMEOUT_CYCLES (TO),
      .FIFO_DEPTH     (DEPTH)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .busAddr   (busAddr),
      .busWrData (busWrData),
      .busWe     (busWe),
      .busRe     (busRe),
      .busRdData (busRdData),
      .done      (done),
      .pass      (pass),
      .fail      (fail),
      .timeout   (timeout),
      .failCode  (failCode),
      .conValid  (conValid),
      .conData   (conData),
      .conReady  (conReady)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rd;
      logic        done, pass, fail, tmo;
      logic [15:0] code;
      logic        cv;
      logic [7:0]  cd;
   } exp_t;

   exp_t q_exp[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   bit   rdy      = 1'b0;

   // Reference model: 0 running, 1 passed, 2 failed, 3 timed out
   int          m_state;
   int unsigned m_cycles;
   logic [15:0] m_code;
   logic [7:0]  m_fifo[$];
   logic [31:0] m_rd;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
      end
   endtask

   // One bus cycle: drive at negedge, advance the model, queue what the DUT shows after the edge
   task automatic cyc(input bit rst_n, input bit we, input bit re,
                      input logic [31:0] addr, input logic [31:0] data);
      bit          hit;
      int          off;
      int unsigned occ;
      bit          popped;
      exp_t        e;
      @(negedge clk);
      reset = rst_n; busWe = we; busRe = re; busAddr = addr; busWrData = data;
      conReady = rdy;
      if (!rst_n) begin
         m_state = 0; m_cycles = 0; m_code = 16'd0; m_fifo.delete(); m_rd = 32'd0;
      end else begin
         hit = (addr[31:4] == BASE[31:4]);
         off = int'(addr[3:2]);
         occ = m_fifo.size();
         if (re && hit) begin
            case (off)
               1:       m_rd = CON_EN ? occ : 32'd0;
               2:       m_rd = m_cycles;
               3:       m_rd = {m_code, 12'd0, m_state == 3, m_state == 2, m_state == 1, m_state != 0};
               default: m_rd = 32'd0;
            endcase
         end
         popped = CON_EN && (occ > 0) && rdy;
         if (popped) void'(m_fifo.pop_front());
         if (CON_EN && we && hit && off == 1 && (occ < DEPTH || popped))
            m_fifo.push_back(data[7:0]);
         if (m_state == 0) begin
            if (we && hit && off == 0 && data == 32'd1) m_state = 1;
            else if (we && hit && off == 0 && data[0]) begin
               m_state = 2; m_code = data[16:1];
            end else if (m_cycles == TO - 1) m_state = 3;
            m_cycles++;
         end
      end
      e.rd = m_rd; e.done = (m_state != 0); e.pass = (m_state == 1);
      e.fail = (m_state == 2); e.tmo = (m_state == 3); e.code = m_code;
      e.cv = (m_fifo.size() > 0); e.cd = e.cv ? m_fifo[0] : 8'd0;
      q_exp.push_back(e);
   endtask

   function automatic logic [31:0] a(input int off);
      return BASE | 32'(off * 4);
   endfunction

   function automatic logic [31:0] raddr();
      logic [31:0] x;
      x = BASE | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) x = x ^ (32'd1 << $urandom_range(4, 31));
      return x;
   endfunction

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1, 0, 0, 32'd0, 32'd0);
   endtask
   task automatic wr(input int off, input logic [31:0] d);
      cyc(1, 1, 0, a(off), d);
   endtask
   task automatic rd(input int off);
      cyc(1, 0, 1, a(off), 32'd0);
   endtask
   task automatic rst(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 32'd0, 32'd0);
   endtask

   // Monitor: compares DUT outputs one step after each queued cycle
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (q_exp.size() > 0) begin
            exp_t e;
            e = q_exp.pop_front();
            chk("rdData",   busRdData,      e.rd);
            chk("done",     32'(done),      32'(e.done));
            chk("pass",     32'(pass),      32'(e.pass));
            chk("fail",     32'(fail),      32'(e.fail));
            chk("timeout",  32'(timeout),   32'(e.tmo));
            chk("failCode", 32'(failCode),  32'(e.code));
            chk("conValid", 32'(conValid),  32'(e.cv));
            if (e.cv || !CON_EN) chk("conData", 32'(conData), 32'(e.cd));
         end
      end
   end

   initial begin
      int r;
      int len;
      logic [31:0] v;
      reset = 1'b0; busWe = 1'b0; busRe = 1'b0; busAddr = 32'd0;
      busWrData = 32'd0; conReady = 1'b0;

      // Pass at cycle 10, then status read
      rst(3); idle(9); wr(0, 32'd1); rd(3); idle(2);
      // Even value ignored, fail code, later pass ignored
      rst(2); wr(0, 32'd4); wr(0, 32'h15); idle(1); wr(0, 32'd1); rd(3); idle(2);
      // Watchdog with no writes, counter frozen afterwards
      rst(2); idle(TO); rd(2); idle(5); rd(2); rd(3);
      // Console "Hi" held, then drained
      rst(2); rdy = 0; wr(1, 32'h48); wr(1, 32'h69); rd(1); idle(1);
      rdy = 1; idle(4);
      // Overfill, then push+pop while full
      rdy = 0;
      for (int i = 0; i < 9; i++) wr(1, 32'(8'hB0 + i));
      rd(1);
      rdy = 1; wr(1, 32'hC0); wr(1, 32'hC1); wr(1, 32'hC2);
      rdy = 0; rd(1); cyc(1, 1, 1, a(1), 32'h5A); rd(1);
      rdy = 1; idle(12);
      // Reset while passed with bytes queued
      rst(2); wr(0, 32'd1); rdy = 0; wr(1, 32'h31); wr(1, 32'h32); wr(1, 32'h33);
      rst(1); rd(2); idle(2); rdy = 1; idle(2);

      // Random episodes
      for (int ep = 0; ep < 20; ep++) begin
         rst(2);
         len = $urandom_range(50, 180);
         for (int c = 0; c < len; c++) begin
            rdy = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 999);
            if (r < 350)      cyc(1, 0, 1, raddr(), $urandom);
            else if (r < 650) cyc(1, 1, 0, a(1) | 32'($urandom_range(0, 3)), $urandom);
            else if (r < 662) begin
               case ($urandom_range(0, 2))
                  0:       v = 32'd1;
                  1:       v = $urandom | 32'd1;
                  default: v = $urandom & ~32'd1;
               endcase
               wr(0, v);
            end
            else if (r < 730) cyc(1, 1, 1, raddr(), $urandom & ~32'd1);
            else if (r < 736) cyc(0, 0, 0, 32'd0, 32'd0);
            else              idle(1);
         end
      end

      idle(2);
      @(posedge clk);
      #3;
      chk("scoreboard_drain", 32'(q_exp.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/test_status_port.md
Name: test_status_port

Overview:
- Memory-mapped responder on the CPU data bus; firmware writes here to report test completion.
- Firmware also uses it to stream console bytes and read a cycle counter.
- Drives done/pass/fail/timeout flags and a console byte stream that the simulation bench consumes.
- Sits beside RAM in top, selected by an address decode.

Parameters:
- BASE_ADDR, 32'hFFFF_FF00, byte address of register block (16-byte aligned).
- TIMEOUT_CYCLES, 50000, watchdog limit in clk cycles; 0 disables the watchdog.
- FIFO_DEPTH, 8, console FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-low.
- busAddr  in  32  data bus byte address.
- busWrData  in  32  write data.
- busWe  in  1  write strobe; one write per cycle.
- busRe  in  1  read strobe.
- busRdData  out  32  read data, registered.
- done  out  1  test has terminated (pass, fail or timeout).
- pass  out  1  firmware reported success.
- fail  out  1  firmware reported failure.
- timeout  out  1  watchdog expired.
- failCode  out  16  code reported with a failure.
- conValid  out  1  console byte available.
- conData  out  8  console byte.
- conReady  in  1  consumer accepts byte when conValid&conReady.

Behaviour:
- Register map, offsets from BASE_ADDR; hit = busAddr[31:4]==BASE_ADDR[31:4]; busAddr[1:0] ignored:
  - 0x0 TOHOST, write-only; reads 0.
  - 0x4 CONSOLE: write pushes busWrData[7:0]; read returns FIFO occupancy.
  - 0x8 CYCLES: read-only 32-bit count since reset; wraps at 2^32.
  - 0xC STATUS: read {failCode[15:0], 12'b0, timeout, fail, pass, done}.
- Reset (reset==0 at posedge):
  - All outputs 0; FSM to RUN.
  - FIFO emptied; cycle and watchdog counters 0.
- FSM states RUN, PASS, FAIL, TIMEOUT; PASS, FAIL and TIMEOUT are terminal until reset.
- TOHOST write in RUN:
  - value==1 -> PASS.
  - odd value≠1 -> FAIL, failCode=value[16:1].
  - even value (incl. 0) ignored.
- Watchdog:
  - Increments every cycle in RUN.
  - Reaching TIMEOUT_CYCLES-1 -> TIMEOUT on next edge.
  - A TOHOST pass/fail write in that same cycle wins over timeout.
- Flags: done = state≠RUN; pass/fail/timeout one-hot with state. All registered and asserted the cycle after the deciding edge.
- Terminal states: TOHOST writes ignored; CYCLES stops counting; console keeps draining.
- Reads: busRdData updated on the edge where busRe&hit; holds its value otherwise (1-cycle latency). Non-hit or busRe=0 leaves it unchanged. Unmapped offsets read 0.
- Console FIFO:
  - Push on CONSOLE write; push while full is dropped (no overwrite).
  - conValid = not empty; conData = head entry (show-ahead).
  - Pop on conValid&conReady.
  - Push and pop in the same cycle when full: pop occurs, push accepted, occupancy unchanged.
  - Push into empty FIFO: conValid rises the next cycle.
- busWe and busRe both high: write takes effect; read returns pre-write value.
- Reset mid-test: state, FIFO, counters and flags all clear on that edge.

Optional Feature:
- TSP_CONSOLE_EN.
- Defined: console FIFO and CONSOLE register as above.
- Undefined:
  - No FIFO instantiated; CONSOLE writes dropped, reads return 0.
  - conValid=0, conData=0; conReady ignored.
  - All other behaviour unchanged.

Decomposition:
- Shared constants header, beside existing constants:
  - Register offsets TSP_OFF_TOHOST/CONSOLE/CYCLES/STATUS.
  - State encodings TSP_RUN/PASS/FAIL/TIMEOUT (2-bit).
  - TOHOST pass value 1.
- Sub-module sync_fifo:
  - Parameters WIDTH, DEPTH; ports push/pop/full/empty/count.
  - Reusable by a future UART.

Test Plan:
- Reset then write TOHOST=1 at cycle 10 -> pass=1, done=1 at cycle 11; STATUS read = 32'h0000_0003.
- Write TOHOST=0x15 -> fail=1, failCode=0x000A; a later TOHOST=1 write is ignored and pass stays 0.
- TIMEOUT_CYCLES=100, no writes -> timeout=1 exactly 100 cycles after reset release; CYCLES read then returns 100, frozen.
- Console: write 'H','i' with conReady=0 -> CONSOLE read=2; raise conReady -> conData 0x48 then 0x69, conValid drops. Writing 9 bytes into depth 8 -> the 9th is dropped.
- Full FIFO with simultaneous push and pop -> occupancy stays 8 and byte order is preserved.
- Assert reset in PASS with 3 bytes queued -> all flags 0, conValid 0, CYCLES read 0 after release; repeat build without TSP_CONSOLE_EN -> conValid never rises.
